// File: rtl/wdb_line_collector_if.sv
// Handshake bundle between the beat source, entry allocator, WDB write port and the
// write-request notification path of wdb_line_collector.
interface wdb_line_collector_if #(
    parameter int unsigned DB_ENTRY_NUM = 16,
    parameter int unsigned BEAT_WIDTH   = 256,
    parameter int unsigned LINE_WIDTH   = 1024,
    parameter int unsigned TXNID_WIDTH  = 16
);
    localparam int unsigned ID_W = $clog2(DB_ENTRY_NUM);

    logic                   in_vld;
    logic                   in_rdy;
    logic [BEAT_WIDTH-1:0]  in_data;
    logic                   in_last;
    logic [TXNID_WIDTH-1:0] in_txnid;

    logic                   alloc_vld;
    logic [ID_W-1:0]        alloc_idx;
    logic                   alloc_rdy;

    logic                   wdb_vld;
    logic [LINE_WIDTH-1:0]  wdb_data;
    logic [ID_W-1:0]        wdb_entry_id;
    logic                   wdb_rdy;

    logic                   done_vld;
    logic [ID_W-1:0]        done_entry_id;
    logic [TXNID_WIDTH-1:0] done_txnid;
    logic                   done_rdy;

    logic                   err;

    // Collector side.
    modport master (
        input  in_vld, in_data, in_last, in_txnid,
        input  alloc_vld, alloc_idx,
        input  wdb_rdy, done_rdy,
        output in_rdy, alloc_rdy,
        output wdb_vld, wdb_data, wdb_entry_id,
        output done_vld, done_entry_id, done_txnid,
        output err
    );

    // Environment side.
    modport slave (
        output in_vld, in_data, in_last, in_txnid,
        output alloc_vld, alloc_idx,
        output wdb_rdy, done_rdy,
        input  in_rdy, alloc_rdy,
        input  wdb_vld, wdb_data, wdb_entry_id,
        input  done_vld, done_entry_id, done_txnid,
        input  err
    );
endinterface

// File: rtl/wdb_line_collector.sv
// Assembles narrow write beats into one WDB line per allocated entry, writes it, then notifies.
// Optional WDB_LINE_COLLECT_LAST_CHECK_EN honours in_last and flags framing errors on err.
module wdb_line_collector #(
    parameter int unsigned DB_ENTRY_NUM = 16,
    parameter int unsigned BEAT_WIDTH   = 256,
    parameter int unsigned LINE_WIDTH   = 1024,
    parameter int unsigned TXNID_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    wdb_line_collector_if.master bus
);
    localparam int unsigned ID_W  = $clog2(DB_ENTRY_NUM);
    localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StNotify} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        entry_q, entry_d;
    logic [TXNID_WIDTH-1:0] txnid_q, txnid_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   alloc_take;
    logic                   beat_take;
    logic                   line_end;

`ifdef WDB_LINE_COLLECT_LAST_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
`endif

    // alloc_rdy is gated by rst_n so nothing is offered while reset is held.
    assign bus.alloc_rdy = rst_n && (state_q == StIdle) && bus.in_vld;
    assign alloc_take    = bus.alloc_vld && bus.alloc_rdy;
    assign bus.in_rdy    = (state_q == StCollect);
    assign beat_take     = bus.in_vld && bus.in_rdy;

    assign bus.wdb_vld       = (state_q == StWrite);
    assign bus.wdb_data      = line_q;
    assign bus.wdb_entry_id  = entry_q;
    assign bus.done_vld      = (state_q == StNotify);
    assign bus.done_entry_id = entry_q;
    assign bus.done_txnid    = txnid_q;

`ifdef WDB_LINE_COLLECT_LAST_CHECK_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        txnid_d  = txnid_q;
        line_d   = line_q;
        cnt_d    = cnt_q;
        line_end = 1'b0;
`ifdef WDB_LINE_COLLECT_LAST_CHECK_EN
        err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // The first beat waits for the next cycle; only the entry is taken here.
                if (alloc_take) begin
                    entry_d = bus.alloc_idx;
                    line_d  = '0;
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (beat_take) begin
                    for (int b = 0; b < int'(BEATS); b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = bus.in_data;
                        end
                    end
                    if (cnt_q == '0) begin
                        txnid_d = bus.in_txnid;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef WDB_LINE_COLLECT_LAST_CHECK_EN
                    line_end = (cnt_q == LastBeat) || bus.in_last;
                    // Framing error: last flag disagrees with the final beat position.
                    err_d    = (cnt_q == LastBeat) != bus.in_last;
`else
                    line_end = (cnt_q == LastBeat);
`endif
                    if (line_end) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (bus.wdb_rdy) begin
                    state_d = StNotify;
                end
            end
            StNotify: begin
                if (bus.done_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            entry_q <= '0;
            txnid_q <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            txnid_q <= txnid_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WDB_LINE_COLLECT_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    wdb_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.wdb_vld && !bus.wdb_rdy) |=>
        (bus.wdb_vld && $stable(bus.wdb_data) && $stable(bus.wdb_entry_id)));

    done_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.done_vld && !bus.done_rdy) |=>
        (bus.done_vld && $stable(bus.done_entry_id) && $stable(bus.done_txnid)));

    err_pulse_a : assert property (@(posedge clk) disable iff (!rst_n)
        bus.err |=> !bus.err);

    one_phase_a : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.in_rdy, bus.wdb_vld, bus.done_vld}));
endmodule

// File: doc/wdb_line_collector.md
# wdb_line_collector

Upstream feeder of the write data buffer (WDB) agent. Accepts write data as narrow beats and obtains a pre-allocated WDB entry index from the agent's allocator. Assembles one full line per transaction and writes it into the WDB through the agent's write port. Then notifies the write-request path that the line is resident, so the arbitrated SRAM write may be issued.

## Interface
Parameters:
- DB_ENTRY_NUM, 16: WDB entries; ID_W = $clog2(DB_ENTRY_NUM).
- BEAT_WIDTH, 256: input beat width.
- LINE_WIDTH, 1024: WDB line width; must be an integer multiple of BEAT_WIDTH.
  - BEATS = LINE_WIDTH/BEAT_WIDTH.
  - CNT_W = max(1, $clog2(BEATS)).
- TXNID_WIDTH, 16: transaction id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_vld  in  1  beat valid.
- in_rdy  out  1  beat ready.
- in_data  in  BEAT_WIDTH  beat data, little-endian beat order.
- in_last  in  1  final beat of line.
- in_txnid  in  TXNID_WIDTH  transaction id; sampled on first beat only.
- alloc_vld  in  1  allocator has a free entry.
- alloc_idx  in  ID_W  offered entry index.
- alloc_rdy  out  1  consume offered entry.
- wdb_vld  out  1  WDB write request.
- wdb_data  out  LINE_WIDTH  assembled line.
- wdb_entry_id  out  ID_W  target entry.
- wdb_rdy  in  1  WDB write accepted; low while the agent serves a read.
- done_vld  out  1  line resident notification.
- done_entry_id  out  ID_W  entry holding the line.
- done_txnid  out  TXNID_WIDTH  captured txnid.
- done_rdy  in  1  notification accepted.
- err  out  1  one-cycle protocol error pulse.

## Operation
FSM states: IDLE, COLLECT, WRITE, NOTIFY. Reset state is IDLE.

- IDLE:
  - alloc_rdy = in_vld. in_rdy = 0.
  - On alloc_vld && alloc_rdy: capture alloc_idx into entry_q, clear line buffer and beat_cnt, go to COLLECT.
  - The first beat is not consumed in this cycle.
- COLLECT:
  - in_rdy = 1.
  - On an accepted beat: line_q[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= in_data.
  - If beat_cnt == 0, capture in_txnid.
  - beat_cnt increments on each accepted beat; it wraps only via the state change.
  - Line end: the accepted beat has beat_cnt == BEATS-1, or in_last is set (see Configuration). Then go to WRITE.
  - Beats never written stay zero.
- WRITE:
  - wdb_vld = 1; wdb_data = line_q; wdb_entry_id = entry_q. All held stable until wdb_rdy.
  - On wdb_rdy, go to NOTIFY.
- NOTIFY:
  - done_vld = 1, done_entry_id = entry_q, done_txnid = txnid_q. Held stable until done_rdy.
  - On done_rdy, go to IDLE.
- Only one line in flight. No new allocation is taken until NOTIFY completes.
- alloc_vld low in IDLE: wait. in_vld is not acknowledged; no timeout.

## Timing
- Reset values: in_rdy, alloc_rdy, wdb_vld, done_vld, err = 0; all data/id outputs = 0; beat_cnt = 0; line_q = 0.
- Minimum latency with BEATS = 4 and all ready signals high:
  - alloc handshake at cycle 0; beats accepted at cycles 1–4.
  - wdb_vld at cycle 5, done_vld at cycle 6.
  - Next alloc_rdy possible at cycle 7.
- wdb_rdy low holds WRITE indefinitely with outputs stable. done_rdy behaves the same in NOTIFY.
- in_vld dropping mid-line: stay in COLLECT, beat_cnt unchanged.
- Reset mid-operation: return to IDLE immediately. Outputs drop to reset values in the same cycle as rst_n falling. The held entry is not returned; the allocator is reset in the same domain.
- err is registered: it asserts the cycle after the offending beat, for exactly one cycle.

## Configuration
- WDB_LINE_COLLECT_LAST_CHECK_EN defined:
  - in_last is honoured. in_last on beat k < BEATS-1 ends the line early; beats above k are zero; err pulses.
  - Beat BEATS-1 without in_last: line ends anyway; err pulses.
- Not defined:
  - in_last is ignored; a line is always exactly BEATS beats.
  - err is tied 0.

## Test plan
- Nominal:
  - Stimulus: alloc_idx = 5, txnid 0x1234, beats 0xA.., 0xB.., 0xC.., 0xD.. with last on beat 3.
  - Response: wdb_vld with wdb_entry_id = 5 and wdb_data = {D,C,B,A}; then done_vld with entry 5, txnid 0x1234; err never asserts.
- Backpressure:
  - Stimulus: wdb_rdy low 7 cycles, done_rdy low 3 cycles.
  - Response: wdb_vld and done_vld held with stable payload. No in_rdy or alloc_rdy asserted until done_rdy completes.
- Allocation stall:
  - Stimulus: in_vld high, alloc_vld low 10 cycles.
  - Response: in_rdy = 0 throughout. The first beat is accepted only the cycle after the alloc handshake.
- Input bubbles:
  - Stimulus: in_vld toggled 1/0 across beats.
  - Response: line identical to the no-bubble case; txnid is the first beat's value even if in_txnid changes later.
- Early last (macro on):
  - Stimulus: in_last on beat 1.
  - Response: upper two beats are zero, err pulses once, wdb write occurs. With the macro off, the same stimulus waits for 4 beats and err stays 0.
- Reset mid-COLLECT:
  - Stimulus: reset after 2 beats, then a new transaction with alloc_idx = 9.
  - Response: all outputs 0 during reset; the new line lands in entry 9 with no residue from the old beats.
